// File: rtl/counter_timer_ctrl.sv
// Run sequencer for an external loadable up/down counter: loads a start value,
// lets the counter step, stops it on the terminal value and reports completion.
module counter_timer_ctrl #(
    parameter int W      = 4,
    parameter bit RELOAD = 1'b0
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         start,
    input  logic [W-1:0] len,
    input  logic         dir,
    input  logic         abort,
    input  logic [W-1:0] cnt_q,
    output logic         cnt_ld,
    output logic         cnt_mode,
    output logic [W-1:0] cnt_d,
    output logic         busy,
    output logic         done,
    output logic         aborted,
    output logic [7:0]   runs
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state_reg, state_next;
    logic [W-1:0] len_reg;
    logic         dir_reg;
    logic [W-1:0] target;
    logic         at_target;
    logic         busy_reg, done_reg, aborted_reg;
    logic [7:0]   runs_reg;

    assign target    = dir_reg ? len_reg : '0;
    assign at_target = (cnt_q == target);
    assign cnt_mode  = dir_reg;

    // Default is "hold": reload the counter with its own value. Only a
    // non-terminal, non-aborted RUN cycle lets the counter step.
    always_comb begin
        state_next = state_reg;
        cnt_ld     = 1'b1;
        cnt_d      = cnt_q;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else begin
                    cnt_d      = dir_reg ? '0 : len_reg;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (abort)          state_next = IDLE;
                else if (at_target) state_next = DONE;
                else                cnt_ld     = 1'b0;
            end
            DONE: begin
                if (abort)       state_next = IDLE;
                else if (RELOAD) state_next = LOAD;
                else             state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= IDLE;
            len_reg     <= '0;
            dir_reg     <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
            runs_reg    <= 8'd0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start) begin
                len_reg <= len;
                dir_reg <= dir;
            end
            // Status flags are registered copies of the state being entered.
            busy_reg    <= (state_next == LOAD) || (state_next == RUN);
            done_reg    <= (state_next == DONE);
            aborted_reg <= abort && (state_reg != IDLE);
            if (state_reg == DONE && !abort) runs_reg <= runs_reg + 8'd1;
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign aborted = aborted_reg;
    assign runs    = runs_reg;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Randomised scoreboard bench for counter_timer_ctrl, with an external
// counter model, a directed auto-reload instance and a mid-run reset.
module tb_counter_timer_ctrl;

    logic       clk = 1'b0;
    logic       clr;
    logic       start, dir, abort;
    logic [3:0] len;
    logic [3:0] cnt_q = 4'd7;
    logic       cnt_ld, cnt_mode;
    logic [3:0] cnt_d;
    logic       busy, done, aborted;
    logic [7:0] runs;

    logic       start2, dir2, abort2;
    logic [3:0] len2;
    logic [3:0] cnt2_q = 4'd0;
    logic       cnt2_ld, cnt2_mode;
    logic [3:0] cnt2_d;
    logic       busy2, done2, aborted2;
    logic [7:0] runs2;

    counter_timer_ctrl #(.W(4), .RELOAD(1'b0)) u_dut (
        .clk(clk), .clr(clr), .start(start), .len(len), .dir(dir), .abort(abort),
        .cnt_q(cnt_q), .cnt_ld(cnt_ld), .cnt_mode(cnt_mode), .cnt_d(cnt_d),
        .busy(busy), .done(done), .aborted(aborted), .runs(runs)
    );

    counter_timer_ctrl #(.W(4), .RELOAD(1'b1)) u_rl (
        .clk(clk), .clr(clr), .start(start2), .len(len2), .dir(dir2), .abort(abort2),
        .cnt_q(cnt2_q), .cnt_ld(cnt2_ld), .cnt_mode(cnt2_mode), .cnt_d(cnt2_d),
        .busy(busy2), .done(done2), .aborted(aborted2), .runs(runs2)
    );

    always #5 clk = ~clk;

    // External counters: load when ld, otherwise step by mode.
    always @(posedge clk) begin
        cnt_q  <= cnt_ld  ? cnt_d  : (cnt_mode  ? cnt_q  + 4'd1 : cnt_q  - 4'd1);
        cnt2_q <= cnt2_ld ? cnt2_d : (cnt2_mode ? cnt2_q + 4'd1 : cnt2_q - 4'd1);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // kind: 2'b10 = done, 2'b01 = aborted
    typedef struct {
        logic [1:0] kind;
        int         cyc;
        int         cnt;
        int         runs;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   runs_due = -1;
    int   runs_exp = 0;
    int   n_txn    = 0;
    int   exp_runs = 0;
    int   held     = 7;
    bit   mon_en   = 1'b0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (runs_due == cyc) begin
                chk("runs_after_done", int'(runs), runs_exp);
                runs_due = -1;
            end
            if (done || aborted) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", int'({done, aborted}), 0);
                end else begin
                    mon_e = sb.pop_front();
                    n_txn++;
                    chk("event_kind",  int'({done, aborted}), int'(mon_e.kind));
                    chk("event_cycle", cyc, mon_e.cyc);
                    chk("held_count",  int'(cnt_q), mon_e.cnt);
                    chk("busy_after_event", int'(busy), 0);
                    if (mon_e.kind == 2'b01) begin
                        chk("runs_on_abort", int'(runs), mon_e.runs);
                    end else begin
                        runs_due = cyc + 1;
                        runs_exp = mon_e.runs;
                    end
                    $display("txn %0d kind=%b cyc=%0d cnt=%0d exp_runs=%0d",
                             n_txn, {done, aborted}, cyc, cnt_q, mon_e.runs);
                end
            end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
                chk("event_timeout", cyc, sb[0].cyc);
                void'(sb.pop_front());
            end
        end
    end

    // Reference: a started run of length n ends n+2 edges after the sampling
    // edge with the counter parked on its terminal value; an abort ends it
    // one edge later with the counter frozen wherever it was.
    task automatic do_run(input int n, input bit d, input bit do_abort,
                          input bit es_en, input bit aws);
        int   c, a, last, es, cv;
        exp_t e;
        @(negedge clk);
        c     = cyc;
        start = 1'b1;
        len   = 4'(n);
        dir   = d;
        abort = aws;
        if (do_abort) begin
            a  = c + 1 + int'($urandom_range(0, n + 1));
            cv = (a == c + 1) ? held : (d ? a - c - 2 : n - (a - c - 2));
            e.kind = 2'b01; e.cyc = a + 1; e.cnt = cv; e.runs = exp_runs;
            last = a + 1;
            held = cv;
        end else begin
            a = -1;
            exp_runs = (exp_runs + 1) % 256;
            e.kind = 2'b10; e.cyc = c + n + 3; e.cnt = d ? n : 0; e.runs = exp_runs;
            last = c + n + 3;
            held = e.cnt;
        end
        sb.push_back(e);
        es = c + 1 + int'($urandom_range(0, (do_abort ? a : last) - c - 1));
        while (cyc < last) begin
            @(negedge clk);
            abort = (cyc == a);
            start = es_en && (cyc == es);
            len   = 4'($urandom);
            dir   = 1'($urandom);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    int dir_tab [6] = '{1, 0, 1, 0, 1, 0};
    int len_tab [6] = '{5, 9, 0, 0, 15, 15};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c, ndone, hv;
        clr = 1'b0; start = 1'b0; len = 4'd0; dir = 1'b0; abort = 1'b0;
        start2 = 1'b0; len2 = 4'd0; dir2 = 1'b0; abort2 = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_runs", int'(runs), 0);
        chk("reset_done", int'({done, aborted}), 0);
        clr = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_hold", int'({cnt_ld, cnt_q}), int'({1'b1, 4'd7}));
        end
        chk("idle_busy", int'(busy), 0);

        mon_en = 1'b1;
        for (int t = 0; t < 6; t++) do_run(len_tab[t], 1'(dir_tab[t]), 1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 394; t++) begin
            if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                abort = 1'b1;
            end
            do_run(int'($urandom_range(0, 15)), 1'($urandom),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                   $urandom_range(0, 7) == 0);
        end
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        // Auto-reload: len 2 up gives a done every 5 cycles until aborted.
        @(negedge clk);
        start2 = 1'b1; len2 = 4'd2; dir2 = 1'b1; c = cyc;
        ndone = 0;
        for (int k = 0; k < 26; k++) begin
            @(negedge clk);
            start2 = 1'b0;
            abort2 = (cyc == c + 16);
            if (done2) begin
                chk("reload_done_cycle", cyc, (ndone < 3) ? c + 5 + 5 * ndone : -1);
                chk("reload_done_cnt", int'(cnt2_q), 2);
                ndone++;
            end
            if (cyc == c + 16) chk("reload_runs", int'(runs2), 3);
            if (cyc == c + 17) chk("reload_aborted", int'(aborted2), 1);
            if (cyc == c + 18) chk("reload_busy_after_abort", int'(busy2), 0);
        end
        abort2 = 1'b0;
        chk("reload_done_count", ndone, 3);

        // Asynchronous reset in the middle of a run.
        @(negedge clk);
        start = 1'b1; len = 4'd10; dir = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_mid_run", int'(busy), 1);
        mon_en = 1'b0;
        sb.delete();
        runs_due = -1;
        clr = 1'b0;
        #1;
        chk("clr_busy", int'(busy), 0);
        chk("clr_runs", int'(runs), 0);
        chk("clr_hold_ld", int'(cnt_ld), 1);
        @(negedge clk);
        clr = 1'b1;
        hv = int'(cnt_q);
        repeat (3) begin
            @(negedge clk);
            chk("hold_after_clr", int'(cnt_q), hv);
        end
        chk("idle_after_clr", int'({busy, done}), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
